// File: rtl/raster_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : raster_fetch_if
//  Description : Assembled-triangle stream from raster_fetch to the transform
//                stage: three vertices, owning instance transform and id,
//                carried over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
interface raster_fetch_if #(
    parameter int VTX_W   = 108,
    parameter int TRANS_W = 384,
    parameter int IID_W   = 8
) ();
    logic               out_valid;
    logic               out_ready;
    logic [VTX_W-1:0]   out_v0;
    logic [VTX_W-1:0]   out_v1;
    logic [VTX_W-1:0]   out_v2;
    logic [TRANS_W-1:0] out_transform;
    logic [IID_W-1:0]   out_inst;

    // Producer side (raster_fetch)
    modport master (
        output out_valid, out_v0, out_v1, out_v2, out_transform, out_inst,
        input  out_ready
    );

    // Consumer side (transform stage)
    modport slave (
        input  out_valid, out_v0, out_v1, out_v2, out_transform, out_inst,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/raster_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : raster_fetch
//  Description : Render-domain walker over raster_mem. Visits instances
//                0..inst_count-1, reads each instance descriptor, fetches every
//                triangle index triple and its three vertices, and streams the
//                assembled triangle plus instance transform downstream.
//  Revision    : 1.0 - initial release
// ============================================================================
module raster_fetch #(
    parameter int MAX_VERT = 8192,
    parameter int MAX_TRI  = 8192,
    parameter int MAX_INST = 256,
    parameter int VIDX_W   = 12,
    parameter int TIDX_W   = 12,
    parameter int VTX_W    = 108,
    parameter int TRANS_W  = 384,
    parameter int DESC_LAT = 3,
    parameter int VA_W     = $clog2(MAX_VERT),
    parameter int TA_W     = $clog2(MAX_TRI),
    parameter int IID_W    = $clog2(MAX_INST)
) (
    input  logic                clk,
    input  logic                rst_render,

    input  logic                start,
    input  logic [IID_W:0]      inst_count,
    output logic                busy,
    output logic                done,

    output logic [IID_W-1:0]    inst_id_rd,
    input  logic [TRANS_W-1:0]  transform_in,
    input  logic [VA_W-1:0]     vert_base_in,
    input  logic [VIDX_W-1:0]   vert_count_in,
    input  logic [TA_W-1:0]     tri_base_in,
    input  logic [TIDX_W-1:0]   tri_count_in,

    output logic [TA_W-1:0]     tri_addr_rd,
    input  logic [3*VIDX_W-1:0] idx_tri_in,

    output logic [VA_W-1:0]     vert_addr_rd,
    input  logic [VTX_W-1:0]    vert_in,

    raster_fetch_if.master      tri_out,

    output logic [15:0]         bad_idx_cnt
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_idle      = 4'd0;
    localparam logic [3:0] c_inst_rd   = 4'd1;
    localparam logic [3:0] c_inst_wait = 4'd2;
    localparam logic [3:0] c_tri_rd    = 4'd3;
    localparam logic [3:0] c_tri_cap   = 4'd4;
    localparam logic [3:0] c_v0        = 4'd5;
    localparam logic [3:0] c_v1        = 4'd6;
    localparam logic [3:0] c_v2        = 4'd7;
    localparam logic [3:0] c_v_cap     = 4'd8;
    localparam logic [3:0] c_emit      = 4'd9;
    localparam logic [3:0] c_done      = 4'd10;

    localparam int              WAIT_W      = $clog2(DESC_LAT + 1);
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(DESC_LAT - 1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [3:0]         r_state;
    logic [IID_W:0]     r_inst_ctr;
    logic [IID_W:0]     r_inst_count;
    logic [WAIT_W-1:0]  r_wait;
    logic [TIDX_W-1:0]  r_tri_ctr;
    logic [TIDX_W-1:0]  r_tri_count;
    logic [VA_W-1:0]    r_vert_base;
    logic [VIDX_W-1:0]  r_vert_count;
    logic [TA_W-1:0]    r_tri_base;
    logic [TRANS_W-1:0] r_transform;
    logic [VIDX_W-1:0]  r_i0;
    logic [VIDX_W-1:0]  r_i1;
    logic [VIDX_W-1:0]  r_i2;
    logic [VTX_W-1:0]   r_v0;
    logic [VTX_W-1:0]   r_v1;
    logic [VTX_W-1:0]   r_v2;
    logic [15:0]        r_bad_cnt;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [3:0]         w_state_nxt;
    logic [3:0]         w_after_inst;
    logic [3:0]         w_after_tri;
    logic [IID_W:0]     w_inst_next;
    logic [TIDX_W-1:0]  w_tri_next;
    logic               w_inst_last;
    logic               w_tri_last;
    logic               w_wait_last;
    logic               w_xfer;
    logic               w_bad;
    logic [VIDX_W-1:0]  w_i0;
    logic [VIDX_W-1:0]  w_i1;
    logic [VIDX_W-1:0]  w_i2;

    assign w_i0 = idx_tri_in[VIDX_W-1:0];
    assign w_i1 = idx_tri_in[2*VIDX_W-1:VIDX_W];
    assign w_i2 = idx_tri_in[3*VIDX_W-1:2*VIDX_W];

    // A triple is dropped when any index lies outside the instance's vertex buffer
    assign w_bad = (w_i0 >= r_vert_count) || (w_i1 >= r_vert_count) ||
                   (w_i2 >= r_vert_count);

    assign w_inst_next = r_inst_ctr + 1'b1;
    assign w_tri_next  = r_tri_ctr + 1'b1;
    assign w_inst_last = (w_inst_next == r_inst_count);
    assign w_tri_last  = (w_tri_next == r_tri_count);
    assign w_wait_last = (r_wait == c_wait_last);
    assign w_xfer      = (r_state == c_emit) && tri_out.out_ready;

    // NEXT_INST and NEXT_TRI cost no cycle: they collapse into these targets
    assign w_after_inst = w_inst_last ? c_done : c_inst_rd;
    assign w_after_tri  = w_tri_last ? w_after_inst : c_tri_rd;

    // Next-state decision
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: begin
                if (start) begin
                    w_state_nxt = (inst_count == '0) ? c_done : c_inst_rd;
                end
            end
            c_inst_rd:   w_state_nxt = c_inst_wait;
            c_inst_wait: begin
                if (w_wait_last) begin
                    w_state_nxt = (tri_count_in == '0) ? w_after_inst : c_tri_rd;
                end
            end
            c_tri_rd:    w_state_nxt = c_tri_cap;
            c_tri_cap:   w_state_nxt = w_bad ? w_after_tri : c_v0;
            c_v0:        w_state_nxt = c_v1;
            c_v1:        w_state_nxt = c_v2;
            c_v2:        w_state_nxt = c_v_cap;
            c_v_cap:     w_state_nxt = c_emit;
            c_emit: begin
                if (w_xfer) begin
                    w_state_nxt = w_after_tri;
                end
            end
            c_done:      w_state_nxt = c_idle;
            default:     w_state_nxt = c_idle;
        endcase
    end

    // State register, walk counters and per-instance descriptor capture
    always_ff @(posedge clk) begin
        if (rst_render) begin
            r_state      <= c_idle;
            r_inst_ctr   <= '0;
            r_inst_count <= '0;
            r_wait       <= '0;
            r_tri_ctr    <= '0;
            r_tri_count  <= '0;
            r_vert_base  <= '0;
            r_vert_count <= '0;
            r_tri_base   <= '0;
            r_transform  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_inst_count <= inst_count;
                        r_inst_ctr   <= '0;
                    end
                end
                c_inst_rd: begin
                    r_wait <= '0;
                end
                c_inst_wait: begin
                    r_wait <= r_wait + 1'b1;
                    if (w_wait_last) begin
                        r_transform  <= transform_in;
                        r_vert_base  <= vert_base_in;
                        r_vert_count <= vert_count_in;
                        r_tri_base   <= tri_base_in;
                        r_tri_count  <= tri_count_in;
                        r_tri_ctr    <= '0;
                        if (tri_count_in == '0) begin
                            r_inst_ctr <= w_inst_next;
                        end
                    end
                end
                c_tri_cap: begin
                    if (w_bad) begin
                        r_tri_ctr <= w_tri_next;
                        if (w_tri_last) begin
                            r_inst_ctr <= w_inst_next;
                        end
                    end
                end
                c_emit: begin
                    if (w_xfer) begin
                        r_tri_ctr <= w_tri_next;
                        if (w_tri_last) begin
                            r_inst_ctr <= w_inst_next;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Index triple and vertex capture; each vertex lands one cycle after its address
    always_ff @(posedge clk) begin
        if (rst_render) begin
            r_i0 <= '0;
            r_i1 <= '0;
            r_i2 <= '0;
            r_v0 <= '0;
            r_v1 <= '0;
            r_v2 <= '0;
        end else begin
            case (r_state)
                c_tri_cap: begin
                    r_i0 <= w_i0;
                    r_i1 <= w_i1;
                    r_i2 <= w_i2;
                end
                c_v1:    r_v0 <= vert_in;
                c_v2:    r_v1 <= vert_in;
                c_v_cap: r_v2 <= vert_in;
                default: begin
                end
            endcase
        end
    end

    // Dropped-triangle counter, sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst_render) begin
            r_bad_cnt <= '0;
        end else if ((r_state == c_tri_cap) && w_bad && (r_bad_cnt != 16'hFFFF)) begin
            r_bad_cnt <= r_bad_cnt + 16'd1;
        end
    end

    // Read addresses are driven only in the states that own them, zero otherwise
    always_comb begin
        inst_id_rd   = '0;
        tri_addr_rd  = '0;
        vert_addr_rd = '0;
        case (r_state)
            c_inst_rd, c_inst_wait: inst_id_rd = r_inst_ctr[IID_W-1:0];
            c_tri_rd:    tri_addr_rd  = r_tri_base + TA_W'(r_tri_ctr);
            c_v0:        vert_addr_rd = r_vert_base + VA_W'(r_i0);
            c_v1:        vert_addr_rd = r_vert_base + VA_W'(r_i1);
            c_v2:        vert_addr_rd = r_vert_base + VA_W'(r_i2);
            default: begin
            end
        endcase
    end

    assign busy        = (r_state != c_idle) && (r_state != c_done);
    assign done        = (r_state == c_done);
    assign bad_idx_cnt = r_bad_cnt;

    // Output payload comes straight from registers, so it holds while stalled
    assign tri_out.out_valid     = (r_state == c_emit);
    assign tri_out.out_v0        = r_v0;
    assign tri_out.out_v1        = r_v1;
    assign tri_out.out_v2        = r_v2;
    assign tri_out.out_transform = r_transform;
    assign tri_out.out_inst      = r_inst_ctr[IID_W-1:0];

endmodule
`default_nettype wire
